// File: rtl/bus_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_n_if
// Purpose  : requester channels plus shared bus master signals of bus_arbiter_n
// Revision : 1.0
// ============================================================================
interface bus_arbiter_n_if #(
    parameter int N_PORTS = 2,
    parameter int XLEN    = 32
);
    localparam int GID_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    // Requester side
    logic [N_PORTS-1:0]      i_req;
    logic [N_PORTS*XLEN-1:0] i_addr;
    logic [N_PORTS-1:0]      i_wr_en;
    logic [N_PORTS*XLEN-1:0] i_wr_data;
    logic [N_PORTS*4-1:0]    i_byte_en;
    logic [N_PORTS-1:0]      o_ready;
    logic [XLEN-1:0]         o_rd_data;
    logic                    o_err;
    logic [GID_W-1:0]        o_grant_id;

    // Shared bus side
    logic                    o_bus_en;
    logic                    o_wr_en;
    logic [XLEN-1:0]         o_addr;
    logic [XLEN-1:0]         o_wr_data;
    logic [3:0]              o_byte_en;
    logic                    i_ack;
    logic [XLEN-1:0]         i_rd_data;

    modport master (
        input  i_req, i_addr, i_wr_en, i_wr_data, i_byte_en, i_ack, i_rd_data,
        output o_ready, o_rd_data, o_err, o_grant_id,
               o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
    );

    modport slave (
        output i_req, i_addr, i_wr_en, i_wr_data, i_byte_en, i_ack, i_rd_data,
        input  o_ready, o_rd_data, o_err, o_grant_id,
               o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_n
// Purpose  : N-port round-robin / fixed-priority bus arbiter with ack timeout
// Revision : 1.0
// ============================================================================
module bus_arbiter_n #(
    parameter int N_PORTS        = 2,
    parameter int XLEN           = 32,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    bus_arbiter_n_if.master bus
);
    localparam int GID_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [CNT_W-1:0] c_tmo_last =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state,   w_state_nxt;
    logic [GID_W-1:0]   r_last,    w_last_nxt;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic [GID_W-1:0]   r_gid,     w_gid_nxt;
    logic [N_PORTS-1:0] r_ready,   w_ready_nxt;
    logic [XLEN-1:0]    r_rd_data, w_rd_data_nxt;
    logic               r_err,     w_err_nxt;
    logic               r_bus_en,  w_bus_en_nxt;
    logic               r_wr_en,   w_wr_en_nxt;
    logic [XLEN-1:0]    r_addr,    w_addr_nxt;
    logic [XLEN-1:0]    r_wr_data, w_wr_data_nxt;
    logic [3:0]         r_byte_en, w_byte_en_nxt;

    logic [GID_W-1:0]   w_winner;
    logic [XLEN-1:0]    w_sel_addr;
    logic               w_sel_wr_en;
    logic [XLEN-1:0]    w_sel_wr_data;
    logic [3:0]         w_sel_byte_en;
    logic [N_PORTS-1:0] w_gid_onehot;
    int                 w_rank;
    int                 w_best_rank;

    // Winner = requesting port with the smallest rank; in round-robin the rank
    // is the distance after the last granted port, so last+1 ranks 0.
    always_comb begin
        w_winner      = '0;
        w_sel_addr    = '0;
        w_sel_wr_en   = 1'b0;
        w_sel_wr_data = '0;
        w_sel_byte_en = '0;
        w_rank        = 0;
        w_best_rank   = N_PORTS;
        for (int p = 0; p < N_PORTS; p++) begin
            if (PRIORITY_MODE != 0)
                w_rank = p;
            else if (p > int'(r_last))
                w_rank = p - int'(r_last) - 1;
            else
                w_rank = p + N_PORTS - int'(r_last) - 1;
            if (bus.i_req[p] && (w_rank < w_best_rank)) begin
                w_best_rank   = w_rank;
                w_winner      = GID_W'(p);
                w_sel_addr    = bus.i_addr[p*XLEN +: XLEN];
                w_sel_wr_en   = bus.i_wr_en[p];
                w_sel_wr_data = bus.i_wr_data[p*XLEN +: XLEN];
                w_sel_byte_en = bus.i_byte_en[p*4 +: 4];
            end
        end
    end

    always_comb begin
        w_gid_onehot = '0;
        for (int p = 0; p < N_PORTS; p++)
            w_gid_onehot[p] = (r_gid == GID_W'(p));
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_gid_nxt     = r_gid;
        w_ready_nxt   = '0;
        w_rd_data_nxt = r_rd_data;
        w_err_nxt     = r_err;
        w_bus_en_nxt  = r_bus_en;
        w_wr_en_nxt   = r_wr_en;
        w_addr_nxt    = r_addr;
        w_wr_data_nxt = r_wr_data;
        w_byte_en_nxt = r_byte_en;
        case (r_state)
            S_IDLE: begin
                if (|bus.i_req) begin
                    w_gid_nxt     = w_winner;
                    w_addr_nxt    = w_sel_addr;
                    w_wr_en_nxt   = w_sel_wr_en;
                    w_wr_data_nxt = w_sel_wr_data;
                    w_byte_en_nxt = w_sel_byte_en;
                    w_bus_en_nxt  = 1'b1;
                    w_state_nxt   = S_BUS;
                end
            end
            S_BUS: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // Ack takes precedence over a timeout landing in the same cycle
                if (bus.i_ack) begin
                    w_rd_data_nxt = bus.i_rd_data;
                    w_err_nxt     = 1'b0;
                    w_bus_en_nxt  = 1'b0;
                    w_ready_nxt   = w_gid_onehot;
                    w_state_nxt   = S_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_tmo_last)) begin
                    w_rd_data_nxt = '0;
                    w_err_nxt     = 1'b1;
                    w_bus_en_nxt  = 1'b0;
                    w_ready_nxt   = w_gid_onehot;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP: begin
                if (PRIORITY_MODE == 0)
                    w_last_nxt = r_gid;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_bus_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_last    <= GID_W'(N_PORTS - 1);
            r_cnt     <= '0;
            r_gid     <= '0;
            r_ready   <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
            r_bus_en  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_byte_en <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gid     <= w_gid_nxt;
            r_ready   <= w_ready_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_err     <= w_err_nxt;
            r_bus_en  <= w_bus_en_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_byte_en <= w_byte_en_nxt;
        end
    end

    assign bus.o_ready    = r_ready;
    assign bus.o_rd_data  = r_rd_data;
    assign bus.o_err      = r_err;
    assign bus.o_grant_id = r_gid;
    assign bus.o_bus_en   = r_bus_en;
    assign bus.o_wr_en    = r_wr_en;
    assign bus.o_addr     = r_addr;
    assign bus.o_wr_data  = r_wr_data;
    assign bus.o_byte_en  = r_byte_en;
endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter_n
// Purpose  : directed bench for bus_arbiter_n (round-robin and fixed-priority)
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter_n;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_n_if #(.N_PORTS(4), .XLEN(32)) rr_if ();
    bus_arbiter_n_if #(.N_PORTS(4), .XLEN(32)) fp_if ();

    bus_arbiter_n #(
        .N_PORTS(4), .XLEN(32), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(4), .CNT_W(4)
    ) u_rr (
        .i_clk(clk), .i_rst(rst), .bus(rr_if.master)
    );

    bus_arbiter_n #(
        .N_PORTS(4), .XLEN(32), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0), .CNT_W(8)
    ) u_fp (
        .i_clk(clk), .i_rst(rst), .bus(fp_if.master)
    );

    typedef struct {
        logic [3:0] req_rr;
        logic [3:0] req_fp;
        logic       bus_en;
        logic [3:0] rr_ready;
        logic [1:0] rr_gid;
        logic [3:0] fp_ready;
        logic [1:0] fp_gid;
    } vec_t;

    vec_t vec [14];

    function automatic logic [31:0] addr_of(input int p);
        return 32'h100 + 32'(p) * 32'h10;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Continuous requests with ack held high: every transaction is
        // IDLE, BUS, RESP, so grants land on every third edge.
        vec[0]  = '{4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd0, 4'b0000, 2'd1};
        vec[1]  = '{4'b1111, 4'b1010, 1'b0, 4'b0001, 2'd0, 4'b0010, 2'd1};
        vec[2]  = '{4'b1111, 4'b1010, 1'b0, 4'b0000, 2'd0, 4'b0000, 2'd1};
        vec[3]  = '{4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd1, 4'b0000, 2'd1};
        vec[4]  = '{4'b1111, 4'b1010, 1'b0, 4'b0010, 2'd1, 4'b0010, 2'd1};
        vec[5]  = '{4'b1111, 4'b1010, 1'b0, 4'b0000, 2'd1, 4'b0000, 2'd1};
        vec[6]  = '{4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd2, 4'b0000, 2'd1};
        vec[7]  = '{4'b1111, 4'b1010, 1'b0, 4'b0100, 2'd2, 4'b0010, 2'd1};
        vec[8]  = '{4'b1111, 4'b1010, 1'b0, 4'b0000, 2'd2, 4'b0000, 2'd1};
        vec[9]  = '{4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd3, 4'b0000, 2'd1};
        vec[10] = '{4'b1111, 4'b1010, 1'b0, 4'b1000, 2'd3, 4'b0010, 2'd1};
        vec[11] = '{4'b1111, 4'b1010, 1'b0, 4'b0000, 2'd3, 4'b0000, 2'd1};
        vec[12] = '{4'b1111, 4'b1010, 1'b1, 4'b0000, 2'd0, 4'b0000, 2'd1};
        vec[13] = '{4'b1111, 4'b1010, 1'b0, 4'b0001, 2'd0, 4'b0010, 2'd1};

        rst = 1'b1;
        rr_if.i_req = '0;  fp_if.i_req = '0;
        rr_if.i_wr_en = '0; fp_if.i_wr_en = '0;
        rr_if.i_wr_data = '0; fp_if.i_wr_data = '0;
        rr_if.i_byte_en = '1; fp_if.i_byte_en = '1;
        rr_if.i_ack = 1'b0; fp_if.i_ack = 1'b0;
        rr_if.i_rd_data = '0; fp_if.i_rd_data = '0;
        for (int p = 0; p < 4; p++) begin
            rr_if.i_addr[p*32 +: 32] = addr_of(p);
            fp_if.i_addr[p*32 +: 32] = addr_of(p);
        end
        step();
        step();

        // Reset state
        chk("rst_rr_bus_en",  32'(rr_if.o_bus_en),   32'd0);
        chk("rst_rr_ready",   32'(rr_if.o_ready),    32'd0);
        chk("rst_rr_gid",     32'(rr_if.o_grant_id), 32'd0);
        chk("rst_rr_rd_data", rr_if.o_rd_data,       32'd0);
        chk("rst_rr_err",     32'(rr_if.o_err),      32'd0);
        chk("rst_rr_addr",    rr_if.o_addr,          32'd0);
        chk("rst_rr_byte_en", 32'(rr_if.o_byte_en),  32'd0);
        chk("rst_fp_bus_en",  32'(fp_if.o_bus_en),   32'd0);
        chk("rst_fp_ready",   32'(fp_if.o_ready),    32'd0);
        rst = 1'b0;

        // Round-robin fairness and fixed-priority dominance
        for (int i = 0; i < 14; i++) begin
            rr_if.i_req = vec[i].req_rr;
            fp_if.i_req = vec[i].req_fp;
            rr_if.i_ack = 1'b1;
            fp_if.i_ack = 1'b1;
            rr_if.i_rd_data = 32'h5A00_0000 + 32'(i);
            fp_if.i_rd_data = 32'h5A00_0000 + 32'(i);
            step();
            chk("tbl_rr_bus_en", 32'(rr_if.o_bus_en),   32'(vec[i].bus_en));
            chk("tbl_fp_bus_en", 32'(fp_if.o_bus_en),   32'(vec[i].bus_en));
            chk("tbl_rr_ready",  32'(rr_if.o_ready),    32'(vec[i].rr_ready));
            chk("tbl_fp_ready",  32'(fp_if.o_ready),    32'(vec[i].fp_ready));
            chk("tbl_rr_gid",    32'(rr_if.o_grant_id), 32'(vec[i].rr_gid));
            chk("tbl_fp_gid",    32'(fp_if.o_grant_id), 32'(vec[i].fp_gid));
            if (vec[i].bus_en) begin
                chk("tbl_rr_addr", rr_if.o_addr, addr_of(int'(vec[i].rr_gid)));
                chk("tbl_fp_addr", fp_if.o_addr, addr_of(int'(vec[i].fp_gid)));
            end
            if (vec[i].rr_ready != 4'b0000) begin
                chk("tbl_rr_rd_data", rr_if.o_rd_data, 32'h5A00_0000 + 32'(i));
                chk("tbl_fp_rd_data", fp_if.o_rd_data, 32'h5A00_0000 + 32'(i));
                chk("tbl_rr_err",     32'(rr_if.o_err), 32'd0);
            end
        end
        rr_if.i_req = '0; fp_if.i_req = '0;
        rr_if.i_ack = 1'b0; fp_if.i_ack = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;

        // Single read: three BUS cycles, ack on the third
        rr_if.i_req = 4'b0001;
        step();
        chk("rd_bus_en_1", 32'(rr_if.o_bus_en), 32'd1);
        chk("rd_addr",     rr_if.o_addr,        32'h100);
        chk("rd_wr_en",    32'(rr_if.o_wr_en),  32'd0);
        step();
        chk("rd_bus_en_2", 32'(rr_if.o_bus_en), 32'd1);
        step();
        chk("rd_bus_en_3", 32'(rr_if.o_bus_en), 32'd1);
        chk("rd_no_ready", 32'(rr_if.o_ready),  32'd0);
        rr_if.i_ack = 1'b1;
        rr_if.i_rd_data = 32'hDEADBEEF;
        step();
        rr_if.i_req = '0;
        rr_if.i_ack = 1'b0;
        chk("rd_bus_en_off", 32'(rr_if.o_bus_en), 32'd0);
        chk("rd_ready",      32'(rr_if.o_ready),  32'h1);
        chk("rd_data",       rr_if.o_rd_data,     32'hDEADBEEF);
        chk("rd_err",        32'(rr_if.o_err),    32'd0);
        step();
        chk("rd_ready_pulse", 32'(rr_if.o_ready), 32'd0);
        chk("rd_data_hold",   rr_if.o_rd_data,    32'hDEADBEEF);
        step();

        // Timeout with no ack, bounded wait
        begin
            int n_bus = 0;
            bit got = 1'b0;
            rr_if.i_req = 4'b0010;
            for (int c = 0; c < 20 && !got; c++) begin
                step();
                if (rr_if.o_bus_en) n_bus++;
                if (rr_if.o_ready != 4'b0000) got = 1'b1;
            end
            chk("tmo_seen",     32'(got),          32'd1);
            chk("tmo_bus_cyc",  32'(n_bus),        32'd4);
            chk("tmo_ready",    32'(rr_if.o_ready), 32'h2);
            chk("tmo_err",      32'(rr_if.o_err),  32'd1);
            chk("tmo_rd_zero",  rr_if.o_rd_data,   32'd0);
        end
        // Request held: re-arbitrated, then ack on the final BUS cycle
        step();
        step();
        chk("tmo2_bus_en", 32'(rr_if.o_bus_en),   32'd1);
        chk("tmo2_gid",    32'(rr_if.o_grant_id), 32'd1);
        step();
        step();
        step();
        chk("tmo2_still_bus", 32'(rr_if.o_bus_en), 32'd1);
        rr_if.i_ack = 1'b1;
        rr_if.i_rd_data = 32'hCAFEF00D;
        step();
        rr_if.i_req = '0;
        rr_if.i_ack = 1'b0;
        chk("tmo2_ready", 32'(rr_if.o_ready), 32'h2);
        chk("tmo2_err",   32'(rr_if.o_err),   32'd0);
        chk("tmo2_data",  rr_if.o_rd_data,    32'hCAFEF00D);
        step();
        step();

        // Write passthrough, requester inputs change during BUS
        rr_if.i_req = 4'b0010;
        rr_if.i_wr_en[1] = 1'b1;
        rr_if.i_wr_data[63:32] = 32'h12345678;
        rr_if.i_byte_en[7:4] = 4'b0011;
        rr_if.i_addr[63:32] = 32'h200;
        step();
        chk("wr_bus_en",  32'(rr_if.o_bus_en),  32'd1);
        chk("wr_wr_en",   32'(rr_if.o_wr_en),   32'd1);
        chk("wr_data",    rr_if.o_wr_data,      32'h12345678);
        chk("wr_byte_en", 32'(rr_if.o_byte_en), 32'h3);
        chk("wr_addr",    rr_if.o_addr,         32'h200);
        rr_if.i_wr_en[1] = 1'b0;
        rr_if.i_wr_data[63:32] = 32'hFFFF0000;
        rr_if.i_byte_en[7:4] = 4'b1100;
        rr_if.i_addr[63:32] = 32'h300;
        step();
        chk("wr_hold_wr_en",   32'(rr_if.o_wr_en),   32'd1);
        chk("wr_hold_data",    rr_if.o_wr_data,      32'h12345678);
        chk("wr_hold_byte_en", 32'(rr_if.o_byte_en), 32'h3);
        chk("wr_hold_addr",    rr_if.o_addr,         32'h200);
        rr_if.i_ack = 1'b1;
        step();
        chk("wr_ready", 32'(rr_if.o_ready), 32'h2);
        rr_if.i_req = '0;
        rr_if.i_ack = 1'b0;
        rr_if.i_byte_en[7:4] = 4'hF;
        rr_if.i_addr[63:32] = addr_of(1);
        step();
        step();

        // Reset mid-BUS aborts and restores the round-robin pointer
        rr_if.i_req = 4'b0001;
        rr_if.i_ack = 1'b1;
        step();
        step();
        chk("rb_ready0", 32'(rr_if.o_ready), 32'h1);
        rr_if.i_req = 4'b0011;
        rr_if.i_ack = 1'b0;
        step();
        step();
        chk("rb_gid_before", 32'(rr_if.o_grant_id), 32'd1);
        chk("rb_bus_before", 32'(rr_if.o_bus_en),   32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rb_bus_off",  32'(rr_if.o_bus_en),   32'd0);
        chk("rb_no_ready", 32'(rr_if.o_ready),    32'd0);
        chk("rb_gid_rst",  32'(rr_if.o_grant_id), 32'd0);
        step();
        chk("rb_no_ready2", 32'(rr_if.o_ready),    32'd0);
        chk("rb_bus_again", 32'(rr_if.o_bus_en),   32'd1);
        chk("rb_gid_after", 32'(rr_if.o_grant_id), 32'd0);
        rr_if.i_req = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
